// File: rtl/i2s_pkg.sv
// Shared constants and helpers for the I2S master transmitter slice.
package i2s_pkg;

   localparam int I2S_BITSIZE  = 24;
   localparam int I2S_SLOTBITS = 32;
   localparam int I2S_CLKDIV   = 8;

   // Width of a counter spanning both channel slots of one frame.
   function automatic int fposWidth(input int slotBits);
      return $clog2(2 * slotBits);
   endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// Bit-clock generator: divides clk down to bclk and tracks the bit position
// within the stereo frame, advancing on each bclk falling edge.
import i2s_pkg::*;

module i2s_clkgen #(
   parameter int CLKDIV   = I2S_CLKDIV,
   parameter int SLOTBITS = I2S_SLOTBITS,
   parameter int FPW      = fposWidth(SLOTBITS)
) (
   input  logic           clk,
   input  logic           reset,
   output logic           bclk,
   output logic           fall_tick,
   output logic [FPW-1:0] fpos,
   output logic           frame_wrap
);

   localparam int             DW        = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
   localparam logic [DW-1:0]  DIV_LAST  = DW'(CLKDIV - 1);
   localparam logic [FPW-1:0] FPOS_LAST = FPW'(2 * SLOTBITS - 1);

   logic [DW-1:0]  r_div;
   logic           r_bclk;
   logic [FPW-1:0] r_fpos;
   logic           w_term;
   logic           w_fall;
   logic           w_wrap;

   assign w_term = (r_div == DIV_LAST);
   assign w_fall = w_term && r_bclk;
   assign w_wrap = w_fall && (r_fpos == FPOS_LAST);

   // fpos resets to the last position so the very first fall tick opens a left slot.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_div  <= '0;
         r_bclk <= 1'b0;
         r_fpos <= FPOS_LAST;
      end else begin
         if (w_term) begin
            r_div  <= '0;
            r_bclk <= ~r_bclk;
         end else begin
            r_div <= r_div + DW'(1);
         end
         if (w_fall) begin
            r_fpos <= w_wrap ? '0 : r_fpos + FPW'(1);
         end
      end
   end

   assign bclk       = r_bclk;
   assign fall_tick  = w_fall;
   assign fpos       = r_fpos;
   assign frame_wrap = w_wrap;

endmodule

// File: rtl/i2s_master_tx.sv
// Stereo I2S transmitter acting as clock master (owns bclk/lrclk).
// Define I2S_MASTER_TX_LEFT_JUSTIFIED_EN for left-justified data instead of standard I2S.
import i2s_pkg::*;

module i2s_master_tx #(
   parameter int BITSIZE  = I2S_BITSIZE,
   parameter int SLOTBITS = I2S_SLOTBITS,
   parameter int CLKDIV   = I2S_CLKDIV
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [BITSIZE-1:0] left_in,
   input  logic [BITSIZE-1:0] right_in,
   input  logic               in_valid,
   output logic               in_ready,
   output logic               bclk,
   output logic               lrclk,
   output logic               sdata,
   output logic               frame_start,
   output logic               underflow
);

   localparam int FPW = fposWidth(SLOTBITS);
   localparam int IW  = (BITSIZE > 1) ? $clog2(BITSIZE) : 1;

   logic               w_fallTick;
   logic               w_frameWrap;
   logic [FPW-1:0]     w_fpos;

   logic [BITSIZE-1:0] r_holdL;
   logic [BITSIZE-1:0] r_holdR;
   logic               r_pending;
   logic [BITSIZE-1:0] r_shadowL;
   logic [BITSIZE-1:0] r_shadowR;
   logic               r_lrclk;
   logic               r_sdata;
   logic               r_frameStart;
   logic               r_underflow;

   logic               w_accept;
   logic               w_load;
   logic [BITSIZE-1:0] w_shadowLNext;
   logic [BITSIZE-1:0] w_shadowRNext;
   int                 w_nextFpos;
   int                 w_slotPos;
   logic               w_nextLr;
   logic [BITSIZE-1:0] w_word;
   logic [IW-1:0]      w_idx;
   logic               w_bit;

   i2s_clkgen #(
      .CLKDIV   (CLKDIV),
      .SLOTBITS (SLOTBITS),
      .FPW      (FPW)
   ) u_clkgen (
      .clk        (clk),
      .reset      (reset),
      .bclk       (bclk),
      .fall_tick  (w_fallTick),
      .fpos       (w_fpos),
      .frame_wrap (w_frameWrap)
   );

   assign w_accept      = in_valid && !r_pending;
   assign w_load        = w_frameWrap && r_pending;
   assign w_shadowLNext = w_load ? r_holdL : r_shadowL;
   assign w_shadowRNext = w_load ? r_holdR : r_shadowR;

   // Serializer looks at the position being entered on this fall tick and at the
   // shadow value that will be current then, so outputs change with bclk falling.
   always_comb begin
      w_nextFpos = w_frameWrap ? 0 : int'(w_fpos) + 1;
      w_nextLr   = (w_nextFpos >= SLOTBITS);
      w_slotPos  = w_nextLr ? w_nextFpos - SLOTBITS : w_nextFpos;
      w_word     = w_nextLr ? w_shadowRNext : w_shadowLNext;
      w_idx      = '0;
      w_bit      = 1'b0;
`ifdef I2S_MASTER_TX_LEFT_JUSTIFIED_EN
      if (w_slotPos < BITSIZE) begin
         w_idx = IW'(BITSIZE - 1 - w_slotPos);
         w_bit = w_word[w_idx];
      end
`else
      if (w_slotPos >= 1 && w_slotPos <= BITSIZE) begin
         w_idx = IW'(BITSIZE - w_slotPos);
         w_bit = w_word[w_idx];
      end
`endif
   end

   // An accept coinciding with a frame load stays in holding; the load uses the old pending.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_holdL      <= '0;
         r_holdR      <= '0;
         r_pending    <= 1'b0;
         r_shadowL    <= '0;
         r_shadowR    <= '0;
         r_lrclk      <= 1'b1;
         r_sdata      <= 1'b0;
         r_frameStart <= 1'b0;
         r_underflow  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_holdL   <= left_in;
            r_holdR   <= right_in;
            r_pending <= 1'b1;
         end else if (w_load) begin
            r_pending <= 1'b0;
         end
         r_shadowL    <= w_shadowLNext;
         r_shadowR    <= w_shadowRNext;
         r_frameStart <= w_frameWrap;
         r_underflow  <= w_frameWrap && !r_pending;
         if (w_fallTick) begin
            r_lrclk <= w_nextLr;
            r_sdata <= w_bit;
         end
      end
   end

   assign in_ready    = !r_pending;
   assign lrclk       = r_lrclk;
   assign sdata       = r_sdata;
   assign frame_start = r_frameStart;
   assign underflow   = r_underflow;

endmodule

// File: tb/tb_i2s_master_tx.sv
// Self-checking bench for i2s_master_tx: frame-level model of queued sample
// pairs, each frame's slots captured at bclk rising edges and compared whole.
module tb_i2s_master_tx;
   import i2s_pkg::*;

   localparam int BITSIZE  = I2S_BITSIZE;
   localparam int SLOTBITS = I2S_SLOTBITS;
   localparam int CLKDIV   = I2S_CLKDIV;
   localparam int FRAME    = 4 * CLKDIV * SLOTBITS;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic [BITSIZE-1:0] left_in = '0;
   logic [BITSIZE-1:0] right_in = '0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic               bclk;
   logic               lrclk;
   logic               sdata;
   logic               frame_start;
   logic               underflow;

   int checkCount = 0;
   int passCount = 0;
   int failCount = 0;
   int cyc = 0;
   int acceptCount = 0;
   int nextStart = 0;

   logic [BITSIZE-1:0] qL[$];
   logic [BITSIZE-1:0] qR[$];
   logic [BITSIZE-1:0] curL = '0;
   logic [BITSIZE-1:0] curR = '0;

   i2s_master_tx #(
      .BITSIZE  (BITSIZE),
      .SLOTBITS (SLOTBITS),
      .CLKDIV   (CLKDIV)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .left_in     (left_in),
      .right_in    (right_in),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .bclk        (bclk),
      .lrclk       (lrclk),
      .sdata       (sdata),
      .frame_start (frame_start),
      .underflow   (underflow)
   );

   always #5 clk = ~clk;

   // Clock cycles elapsed since reset was released.
   always @(posedge clk) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   always @(posedge clk) begin
      if (!reset && in_valid && in_ready) acceptCount <= acceptCount + 1;
   end

   // Expected slot contents read MSB-first from bit position 0 of the slot.
   function automatic logic [SLOTBITS-1:0] slotVec(input logic [BITSIZE-1:0] w);
      logic [SLOTBITS-1:0] v;
      v = SLOTBITS'(w);
`ifdef I2S_MASTER_TX_LEFT_JUSTIFIED_EN
      return v << (SLOTBITS - BITSIZE);
`else
      return v << (SLOTBITS - BITSIZE - 1);
`endif
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Offers one sample pair and records it in the model queue.
   task automatic applyStimulus(input logic [BITSIZE-1:0] l, input logic [BITSIZE-1:0] r);
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 2 * FRAME) begin
         @(negedge clk);
         n++;
      end
      checkOutput("inReadyBeforeOffer", in_ready, 1'b1);
      left_in  = l;
      right_in = r;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("inReadyAfterAccept", in_ready, 1'b0);
      qL.push_back(l);
      qR.push_back(r);
   endtask

   task automatic captureFrame(output logic [SLOTBITS-1:0] capL, output logic [SLOTBITS-1:0] capR,
                               output logic [2*SLOTBITS-1:0] capLr, output int timeouts);
      logic prev;
      int   n;
      capL = '0;
      capR = '0;
      capLr = '0;
      timeouts = 0;
      prev = bclk;
      for (int b = 0; b < 2 * SLOTBITS; b++) begin
         n = 0;
         forever begin
            @(negedge clk);
            n++;
            if ((bclk === 1'b1 && prev === 1'b0) || n >= 4 * CLKDIV) break;
            prev = bclk;
         end
         if (n >= 4 * CLKDIV && bclk !== 1'b1) timeouts++;
         prev = bclk;
         capLr[2*SLOTBITS-1-b] = lrclk;
         if (b < SLOTBITS) capL[SLOTBITS-1-b] = sdata;
         else              capR[2*SLOTBITS-1-b] = sdata;
      end
   endtask

   // Checks one whole frame against the model; atStart means frame_start is visible now.
   task automatic frameCheck(input bit atStart);
      logic [SLOTBITS-1:0]   capL;
      logic [SLOTBITS-1:0]   capR;
      logic [2*SLOTBITS-1:0] capLr;
      logic [2*SLOTBITS-1:0] expLr;
      int                    timeouts;
      bit                    expUnder;
      int                    n;
      if (!atStart) begin
         n = 0;
         while (frame_start !== 1'b1 && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
         end
         checkOutput("frameStartSeen", frame_start, 1'b1);
      end
      checkOutput("frameStartCycle", 64'(cyc), 64'(nextStart));
      expUnder = (qL.size() == 0);
      checkOutput("underflow", underflow, expUnder);
      checkOutput("lrclkAtStart", lrclk, 1'b0);
      if (!expUnder) begin
         curL = qL.pop_front();
         curR = qR.pop_front();
      end
      nextStart += FRAME;
      @(negedge clk);
      checkOutput("pulseWidth", {frame_start, underflow}, 2'b00);
      captureFrame(capL, capR, capLr, timeouts);
      expLr = {{SLOTBITS{1'b0}}, {SLOTBITS{1'b1}}};
      checkOutput("bclkTimeouts", 64'(timeouts), 64'd0);
      checkOutput("leftSlot", capL, slotVec(curL));
      checkOutput("rightSlot", capR, slotVec(curR));
      checkOutput("lrclkPattern", capLr, expLr);
   endtask

   initial begin
      int                 n;
      int                 acceptBase;
      logic [BITSIZE-1:0] rl;
      logic [BITSIZE-1:0] rr;

      // Reset values.
      repeat (3) @(negedge clk);
      checkOutput("rstBclk", bclk, 1'b0);
      checkOutput("rstLrclk", lrclk, 1'b1);
      checkOutput("rstSdata", sdata, 1'b0);
      checkOutput("rstInReady", in_ready, 1'b1);
      checkOutput("rstFrameStart", frame_start, 1'b0);
      checkOutput("rstUnderflow", underflow, 1'b0);

      // First bclk rise and first, empty frame.
      reset = 1'b0;
      nextStart = 2 * CLKDIV;
      n = 0;
      while (bclk !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput("firstBclkRise", 64'(cyc), 64'(CLKDIV));
      frameCheck(1'b0);

      // Directed extreme values.
      applyStimulus(24'h800001, 24'h7FFFFF);
      frameCheck(1'b0);

      // Random pairs, one per frame.
      for (int i = 0; i < 2; i++) begin
         applyStimulus(BITSIZE'($urandom()), BITSIZE'($urandom()));
         frameCheck(1'b0);
      end

      // No new sample: underflow and replay.
      frameCheck(1'b0);

      // Continuous in_valid: one accept per frame, no underflow.
      acceptBase = acceptCount;
      left_in  = BITSIZE'($urandom());
      right_in = BITSIZE'($urandom());
      in_valid = 1'b1;
      qL.push_back(left_in);
      qR.push_back(right_in);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         checkOutput("contInReadyLow", in_ready, 1'b0);
         left_in  = BITSIZE'($urandom());
         right_in = BITSIZE'($urandom());
         qL.push_back(left_in);
         qR.push_back(right_in);
         frameCheck(1'b0);
      end
      in_valid = 1'b0;
      checkOutput("contAcceptCount", 64'(acceptCount - acceptBase), 64'd4);
      frameCheck(1'b0);

      // in_valid rises in the load cycle with nothing pending.
      n = 0;
      while (cyc != nextStart - 1 && n < 2 * FRAME) begin
         @(negedge clk);
         n++;
      end
      rl = BITSIZE'($urandom());
      rr = BITSIZE'($urandom());
      left_in  = rl;
      right_in = rr;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("loadCycleAccept", in_ready, 1'b0);
      frameCheck(1'b1);
      qL.push_back(rl);
      qR.push_back(rr);
      frameCheck(1'b0);

      // Reset in the middle of the right slot discards the pending pair.
      applyStimulus(BITSIZE'($urandom()), BITSIZE'($urandom()));
      n = 0;
      while (frame_start !== 1'b1 && n < 2 * FRAME) begin
         @(negedge clk);
         n++;
      end
      checkOutput("preResetFrameStart", frame_start, 1'b1);
      void'(qL.pop_front());
      void'(qR.pop_front());
      applyStimulus(BITSIZE'($urandom()), BITSIZE'($urandom()));
      repeat (SLOTBITS * 2 * CLKDIV + 80) @(negedge clk);
      checkOutput("lrclkMidRight", lrclk, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("midRstBclk", bclk, 1'b0);
      checkOutput("midRstLrclk", lrclk, 1'b1);
      checkOutput("midRstSdata", sdata, 1'b0);
      checkOutput("midRstInReady", in_ready, 1'b1);
      @(negedge clk);
      reset = 1'b0;
      qL.delete();
      qR.delete();
      curL = '0;
      curR = '0;
      nextStart = 2 * CLKDIV;
      frameCheck(1'b0);

      // Normal operation resumes after reset.
      applyStimulus(BITSIZE'($urandom()), BITSIZE'($urandom()));
      frameCheck(1'b0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
